// File: rtl/sobel_crop_share_arbiter.sv
// Round-robin arbiter sharing one ap_ctrl_hs crop unit between N_REQ requesters.
// It includes a per-operation timeout and sticky error reporting.
module sobel_crop_share_arbiter #(
  parameter int unsigned N_REQ   = 4,
  parameter int unsigned DW      = 16,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic                ap_clk,
  input  logic                ap_rst_n,
  input  logic [N_REQ-1:0]    req_start,
  input  logic [N_REQ*DW-1:0] req_din,
  output logic [N_REQ-1:0]    req_ready,
  output logic [N_REQ-1:0]    req_done,
  output logic [N_REQ*DW-1:0] req_dout,
  output logic                u_start,
  output logic [DW-1:0]       u_din,
  input  logic                u_ready,
  input  logic                u_done,
  input  logic [DW-1:0]       u_dout,
  output logic                busy,
  output logic                err_timeout,
  output logic [2:0]          err_idx,
  input  logic                err_clr
);

  localparam int unsigned IW = $clog2(N_REQ);
  localparam int unsigned CW = $clog2(TIMEOUT);

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StResp} state_e;

  state_e              state_q, state_d;
  logic [IW-1:0]       rr_ptr_q, rr_ptr_d;
  logic [IW-1:0]       gnt_q, gnt_d;
  logic [DW-1:0]       opnd_q, opnd_d;
  logic [CW-1:0]       tcnt_q, tcnt_d;
  logic                err_q, err_d;
  logic [2:0]          eidx_q, eidx_d;
  logic [N_REQ*DW-1:0] dout_q, dout_d;

  logic          found;
  logic [IW-1:0] pick;
  logic          abort;

  // Scan requesters starting at rr_ptr; the first one asserted wins.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      logic [IW-1:0] k;
      k = IW'((32'(rr_ptr_q) + i) % N_REQ);
      if (!found && req_start[k]) begin
        found = 1'b1;
        pick  = k;
      end
    end
  end

  assign abort = (tcnt_q == CW'(TIMEOUT - 1));

  always_comb begin
    state_d   = state_q;
    rr_ptr_d  = rr_ptr_q;
    gnt_d     = gnt_q;
    opnd_d    = opnd_q;
    tcnt_d    = tcnt_q;
    err_d     = err_q;
    eidx_d    = eidx_q;
    dout_d    = dout_q;
    u_start   = 1'b0;
    u_din     = '0;
    req_ready = '0;
    req_done  = '0;

    if (err_clr) begin
      err_d  = 1'b0;
      eidx_d = '0;
    end

    unique case (state_q)
      StIdle: begin
        if (found) begin
          gnt_d   = pick;
          opnd_d  = req_din[pick*DW +: DW];
          tcnt_d  = '0;
          state_d = StIssue;
        end
      end
      StIssue, StWait: begin
        tcnt_d = tcnt_q + 1'b1;
        if (state_q == StIssue) begin
          u_start = 1'b1;
          u_din   = opnd_q;
          // The counter is zero only in the first ISSUE cycle.
          if (tcnt_q == '0) req_ready[gnt_q] = 1'b1;
        end
        if (abort) begin
          dout_d[gnt_q*DW +: DW] = '0;
          err_d                  = 1'b1;
          if (!err_q || err_clr) eidx_d = 3'(gnt_q);
          state_d                = StResp;
        end else if (state_q == StIssue) begin
          if (u_ready && u_done) begin
            dout_d[gnt_q*DW +: DW] = u_dout;
            state_d                = StResp;
          end else if (u_ready) begin
            state_d = StWait;
          end
        end else if (u_done) begin
          dout_d[gnt_q*DW +: DW] = u_dout;
          state_d                = StResp;
        end
      end
      StResp: begin
        // The result slice was written on entry, so it is valid alongside req_done.
        req_done[gnt_q] = 1'b1;
        rr_ptr_d        = (gnt_q == IW'(N_REQ - 1)) ? '0 : gnt_q + 1'b1;
        state_d         = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state_q  <= StIdle;
      rr_ptr_q <= '0;
      gnt_q    <= '0;
      opnd_q   <= '0;
      tcnt_q   <= '0;
      err_q    <= 1'b0;
      eidx_q   <= '0;
      dout_q   <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      gnt_q    <= gnt_d;
      opnd_q   <= opnd_d;
      tcnt_q   <= tcnt_d;
      err_q    <= err_d;
      eidx_q   <= eidx_d;
      dout_q   <= dout_d;
    end
  end

  assign busy        = (state_q != StIdle);
  assign err_timeout = err_q;
  assign err_idx     = eidx_q;
  assign req_dout    = dout_q;

endmodule

// File: tb/tb_sobel_crop_share_arbiter.sv
// Randomised bench for sobel_crop_share_arbiter with a behavioural crop unit and a
// round-robin reference model.
module tb_sobel_crop_share_arbiter;
  localparam int N  = 4;
  localparam int DW = 16;

  logic          ap_clk = 1'b0;
  logic          ap_rst_n = 1'b0;
  logic [N-1:0]  req_start = '0;
  logic [N*DW-1:0] req_din = '0;
  logic [N-1:0]  req_ready, req_done;
  logic [N*DW-1:0] req_dout;
  logic          u_start, u_ready, u_done;
  logic [DW-1:0] u_din, u_dout;
  logic          busy, err_timeout;
  logic [2:0]    err_idx;
  logic          err_clr = 1'b0;

  int n_tests = 0;
  int n_fail  = 0;

  sobel_crop_share_arbiter #(.N_REQ(N), .DW(DW), .TIMEOUT(64)) dut (
    .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .req_start(req_start), .req_din(req_din),
    .req_ready(req_ready), .req_done(req_done), .req_dout(req_dout), .u_start(u_start),
    .u_din(u_din), .u_ready(u_ready), .u_done(u_done), .u_dout(u_dout), .busy(busy),
    .err_timeout(err_timeout), .err_idx(err_idx), .err_clr(err_clr)
  );

  always #5 ap_clk = ~ap_clk;

  function automatic logic [DW-1:0] fx(input logic [DW-1:0] x);
    return x ^ 16'h01DC;
  endfunction

  // Behavioural crop unit: ready after rdy_dly stalled cycles, done done_lat cycles later.
  int rdy_dly = 0;
  int done_lat = 0;
  bit never_done = 1'b0;
  int st_cnt, lat_cnt;
  logic [DW-1:0] pend;
  always @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      st_cnt <= 0; lat_cnt <= 0; pend <= '0;
    end else begin
      st_cnt <= (u_start && !u_ready) ? st_cnt + 1 : 0;
      if (u_start && u_ready) begin
        pend <= u_din; lat_cnt <= done_lat;
      end else if (lat_cnt > 0) begin
        lat_cnt <= lat_cnt - 1;
      end
    end
  end
  assign u_ready = u_start && (st_cnt >= rdy_dly);
  assign u_done  = !never_done && ((done_lat == 0) ? (u_start && u_ready) : (lat_cnt == 1));
  assign u_dout  = (done_lat == 0) ? fx(u_din) : fx(pend);

  // Event recorder
  int cyc = 0;
  always @(posedge ap_clk) cyc <= cyc + 1;
  int rdy_idx[$], rdy_cyc[$], done_idx[$], done_cyc[$];
  logic [DW-1:0] done_val[$];
  int multi_cnt = 0;
  always @(negedge ap_clk) begin
    if (ap_rst_n) begin
      if ($countones(req_ready) > 1 || $countones(req_done) > 1) multi_cnt <= multi_cnt + 1;
      for (int i = 0; i < N; i++) begin
        if (req_ready[i]) begin rdy_idx.push_back(i); rdy_cyc.push_back(cyc); end
        if (req_done[i]) begin
          done_idx.push_back(i); done_cyc.push_back(cyc); done_val.push_back(req_dout[i*DW +: DW]);
        end
      end
    end
  end

  // Reference model state
  int model_rr = 0;
  int exp_g[$];
  logic [DW-1:0] din_m [N];
  logic [DW-1:0] exp_dout [N];

  task automatic predict(input logic [N-1:0] mask);
    logic [N-1:0] m = mask;
    exp_g.delete();
    while (m != '0) begin
      for (int i = 0; i < N; i++) begin
        int k = (model_rr + i) % N;
        if (m[k]) begin
          exp_g.push_back(k); m[k] = 1'b0; model_rr = (k + 1) % N;
          break;
        end
      end
    end
  endtask

  task automatic run_ops(input int n, input int budget, output bit ok);
    int s = done_idx.size();
    int k = 0;
    while (done_idx.size() - s < n && k < budget) begin
      @(negedge ap_clk); #1; k++;
      req_start = req_start & ~req_ready;
    end
    ok = (done_idx.size() - s >= n);
  endtask

  task automatic test_reset;
    n_tests++;
    if ({busy, u_start, req_ready, req_done, err_timeout, err_idx} !== '0 || req_dout !== '0) begin
      n_fail++; $display("FAIL reset_hold: busy=%b u_start=%b ready=%b done=%b err=%b idx=%0d dout=%h want all 0",
                         busy, u_start, req_ready, req_done, err_timeout, err_idx, req_dout);
    end
    ap_rst_n = 1'b1;
    for (int i = 0; i < N; i++) exp_dout[i] = '0;
    @(negedge ap_clk); #1;
    n_tests++;
    if ({busy, u_start, req_ready, req_done} !== '0 || u_din !== '0) begin
      n_fail++; $display("FAIL reset_idle: busy=%b u_start=%b ready=%b done=%b u_din=%h want 0",
                         busy, u_start, req_ready, req_done, u_din);
    end
  endtask

  task automatic test_single;
    rdy_dly = 0; done_lat = 0;
    din_m[2] = 16'h0123; req_din[2*DW +: DW] = 16'h0123; req_start[2] = 1'b1;
    @(negedge ap_clk); #1;
    n_tests++;
    if (req_ready !== 4'b0100 || u_start !== 1'b1 || u_din !== 16'h0123) begin
      n_fail++; $display("FAIL single_issue: ready=%b u_start=%b u_din=%h want 0100 1 0123",
                         req_ready, u_start, u_din);
    end
    req_start[2] = 1'b0;
    @(negedge ap_clk); #1;
    n_tests++;
    if (req_done !== 4'b0100 || req_dout[2*DW +: DW] !== 16'h00FF) begin
      n_fail++; $display("FAIL single_done: done=%b dout2=%h want 0100 00ff",
                         req_done, req_dout[2*DW +: DW]);
    end
    model_rr = 3; exp_dout[2] = 16'h00FF;
    @(negedge ap_clk); #1;
    n_tests++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL single_idle: busy=%b want 0", busy); end
  endtask

  task automatic test_mask_round(input string nm, input logic [N-1:0] mask, input bit rel);
    int rs = rdy_idx.size();
    int ds = done_idx.size();
    bit ok;
    logic [N*DW-1:0] ev;
    for (int i = 0; i < N; i++)
      if (mask[i]) begin din_m[i] = DW'($urandom); req_din[i*DW +: DW] = din_m[i]; end
    req_start = req_start | mask;
    if (rel) ap_rst_n = 1'b1;
    predict(mask);
    run_ops(exp_g.size(), 20 * exp_g.size() + 10, ok);
    n_tests++;
    if (!ok || rdy_idx.size() - rs != exp_g.size()) begin
      n_fail++; $display("FAIL %s count: readies=%0d dones=%0d want %0d", nm,
                         rdy_idx.size() - rs, done_idx.size() - ds, exp_g.size());
    end
    for (int j = 0; j < exp_g.size(); j++) begin
      n_tests++;
      if (rs + j >= rdy_idx.size() || ds + j >= done_idx.size() || rdy_idx[rs+j] !== exp_g[j] ||
          done_idx[ds+j] !== exp_g[j] || done_val[ds+j] !== fx(din_m[exp_g[j]])) begin
        n_fail++; $display("FAIL %s op%0d: ready=%0d done=%0d val=%h want grant %0d val %h", nm, j,
                           rdy_idx[rs+j], done_idx[ds+j], done_val[ds+j], exp_g[j],
                           fx(din_m[exp_g[j]]));
      end
      exp_dout[exp_g[j]] = fx(din_m[exp_g[j]]);
    end
    for (int i = 0; i < N; i++) ev[i*DW +: DW] = exp_dout[i];
    n_tests++;
    if (req_dout !== ev) begin
      n_fail++; $display("FAIL %s dout_vec: got %h want %h", nm, req_dout, ev);
    end
  endtask

  task automatic test_reset_mid;
    int p = model_rr;
    bit seen = 1'b0;
    logic [N-1:0] m = 4'b0001;
    done_lat = 10; rdy_dly = 0;
    din_m[2] = DW'($urandom); req_din[2*DW +: DW] = din_m[2]; req_start[2] = 1'b1;
    for (int k = 0; k < 10 && !seen; k++) begin
      @(negedge ap_clk); #1;
      if (req_ready[2]) begin seen = 1'b1; req_start[2] = 1'b0; end
    end
    @(negedge ap_clk); #1;
    n_tests++;
    if (!seen || busy !== 1'b1 || u_start !== 1'b0) begin
      n_fail++; $display("FAIL mid_wait: seen=%b busy=%b u_start=%b want 1 1 0", seen, busy, u_start);
    end
    ap_rst_n = 1'b0; #1;
    n_tests++;
    if ({busy, u_start, req_ready, req_done} !== '0 || req_dout !== '0) begin
      n_fail++; $display("FAIL mid_reset: busy=%b u_start=%b ready=%b done=%b dout=%h want 0",
                         busy, u_start, req_ready, req_done, req_dout);
    end
    model_rr = 0;
    for (int i = 0; i < N; i++) exp_dout[i] = '0;
    @(negedge ap_clk); #1;
    ap_rst_n = 1'b1; done_lat = 2;
    m[p] = 1'b1;
    test_mask_round("after_reset", m, 1'b0);
  endtask

  task automatic test_all_from_reset;
    int mc;
    ap_rst_n = 1'b0; req_start = '0; done_lat = 3; rdy_dly = 0;
    @(negedge ap_clk); #1;
    model_rr = 0; mc = multi_cnt;
    for (int i = 0; i < N; i++) exp_dout[i] = '0;
    test_mask_round("all_from_reset", 4'hF, 1'b1);
    n_tests++;
    if (multi_cnt !== mc) begin
      n_fail++; $display("FAIL all_onehot: multi-bit cycles=%0d want 0", multi_cnt - mc);
    end
  endtask

  task automatic test_ready_delay;
    int i = $urandom_range(0, N - 1);
    logic [DW-1:0] d = DW'($urandom);
    logic [DW-1:0] dv = '0;
    int us = 0, rc = 0, bad = 0;
    bit dn = 1'b0;
    rdy_dly = 5; done_lat = 1;
    din_m[i] = d; req_din[i*DW +: DW] = d; req_start[i] = 1'b1;
    for (int k = 0; k < 40 && !dn; k++) begin
      @(negedge ap_clk); #1;
      if (u_start) begin us++; if (u_din !== d) bad++; end
      if (req_ready != '0) rc++;
      if (req_ready[i]) req_start[i] = 1'b0;
      if (req_done[i]) begin dn = 1'b1; dv = req_dout[i*DW +: DW]; end
    end
    n_tests++;
    if (!dn || us != 6 || rc != 1 || bad != 0 || dv !== fx(d)) begin
      n_fail++; $display("FAIL ready_delay: done=%b ustart_cyc=%0d readies=%0d din_bad=%0d val=%h want 1 6 1 0 %h",
                         dn, us, rc, bad, dv, fx(d));
    end
    model_rr = (i + 1) % N; exp_dout[i] = fx(d);
    rdy_dly = 0;
  endtask

  task automatic test_random;
    for (int r = 0; r < 8; r++) begin
      rdy_dly = $urandom_range(0, 3); done_lat = $urandom_range(0, 4);
      test_mask_round($sformatf("random%0d", r), N'($urandom_range(1, 15)), 1'b0);
    end
  endtask

  task automatic test_timeout;
    int first = $urandom_range(0, N - 1);
    int i = first;
    never_done = 1'b1; rdy_dly = 0; done_lat = 0;
    for (int r = 0; r < 2; r++) begin
      int rs = rdy_idx.size();
      int ds = done_idx.size();
      bit ok;
      if (r == 1) i = (first + 1 + $urandom_range(0, N - 2)) % N;
      req_start[i] = 1'b1;
      run_ops(1, 100, ok);
      n_tests++;
      if (!ok || rs >= rdy_idx.size() || done_cyc[ds] - rdy_cyc[rs] != 64 || done_idx[ds] !== i ||
          done_val[ds] !== '0) begin
        n_fail++; $display("FAIL timeout%0d_abort: done=%b lat=%0d idx=%0d val=%h want 1 64 %0d 0", r,
                           ok, done_cyc[ds] - rdy_cyc[rs], done_idx[ds], done_val[ds], i);
      end
      n_tests++;
      if (err_timeout !== 1'b1 || err_idx !== 3'(first)) begin
        n_fail++; $display("FAIL timeout%0d_err: err=%b idx=%0d want 1 %0d", r, err_timeout,
                           err_idx, first);
      end
      model_rr = (i + 1) % N; exp_dout[i] = '0;
    end
    err_clr = 1'b1;
    @(negedge ap_clk); #1;
    err_clr = 1'b0;
    n_tests++;
    if (err_timeout !== 1'b0 || err_idx !== 3'd0) begin
      n_fail++; $display("FAIL timeout_clr: err=%b idx=%0d want 0 0", err_timeout, err_idx);
    end
    never_done = 1'b0;
  endtask

  initial begin
    repeat (3) @(negedge ap_clk);
    #1;
    test_reset;
    test_single;
    test_mask_round("rr_wrap", 4'b1001, 1'b0);
    test_reset_mid;
    test_all_from_reset;
    test_ready_delay;
    test_random;
    test_timeout;
    n_tests++;
    if (multi_cnt !== 0) begin
      n_fail++; $display("FAIL onehot_global: multi-bit cycles=%0d want 0", multi_cnt);
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, failed=%0d", n_fail);
    $fatal(1, "watchdog expired");
  end

endmodule
